poly_dds: RTL and testbench

Polyphonic, time-multiplexed direct digital synthesiser: VOICES independent phase accumulators share one note-step ROM and one sine ROM, and each sample request sweeps all voices and outputs their signed sum. It sits between the MIDI/note front end (per-voice note, gate and waveform writes) and the 48 kHz audio output path (one query per sample period). Each voice can produce a sine, saw or square wave.

---
 rtl/poly_dds_pkg.sv | 24 ++
 rtl/note_lookup.sv | 43 ++++
 rtl/poly_dds_voice_bank.sv | 68 ++++++
 rtl/sine_lookup.sv | 35 +++
 rtl/poly_dds.sv | 179 +++++++++++++++++
 tb/tb_poly_dds.sv | 220 ++++++++++++++++++++++
 6 files changed

// File: rtl/poly_dds_pkg.sv
// Shared types and helpers for the polyphonic DDS: waveform select, sweep FSM states
// and the square-wave amplitude.
package poly_dds_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SAW    = 2'd1,
    WAVE_SQUARE = 2'd2,
    WAVE_OFF    = 2'd3
  } wave_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Largest positive value of a w-bit signed sample: 2^(w-1)-1.
  function automatic longint unsigned square_amp(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/note_lookup.sv
// Note-step ROM: phase increment per MIDI note at 48 kHz for a 16-bit phase.
// Top-octave steps are tabulated and lower octaves are derived by right shifts.
module note_lookup #(
  parameter int PH_WDTH = 16
) (
  input  logic               clk,
  input  logic [6:0]         addr,
  output logic [PH_WDTH-1:0] step
);

  logic [3:0]  oct;
  logic [3:0]  semi;
  logic [15:0] base;
  logic [15:0] shifted;

  always_comb begin
    oct  = 4'(addr / 7'd12);
    semi = 4'(addr % 7'd12);
    base = 16'd0;
    // Steps for MIDI notes 120..131 (C9 upwards), rounded.
    case (semi)
      4'd0:    base = 16'd11431;
      4'd1:    base = 16'd12110;
      4'd2:    base = 16'd12831;
      4'd3:    base = 16'd13594;
      4'd4:    base = 16'd14402;
      4'd5:    base = 16'd15258;
      4'd6:    base = 16'd16166;
      4'd7:    base = 16'd17127;
      4'd8:    base = 16'd18145;
      4'd9:    base = 16'd19224;
      4'd10:   base = 16'd20367;
      4'd11:   base = 16'd21578;
      default: base = 16'd0;
    endcase
    shifted = base >> (4'd10 - oct);
  end

  always_ff @(posedge clk) begin
    step <= PH_WDTH'(shifted);
  end

endmodule

// File: rtl/poly_dds_voice_bank.sv
// Per-voice note, gate, wave and phase registers with a write port, a combinational
// issue read port and a phase update port. POLY_DDS_PHASE_RESET_EN: gate rise clears phase.
module poly_dds_voice_bank
  import poly_dds_pkg::*;
#(
  parameter int VOICES     = 4,
  parameter int VOICE_WDTH = 2,
  parameter int PH_WDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [VOICE_WDTH-1:0] wr_voice,
  input  logic [6:0]            wr_note,
  input  logic                  wr_gate,
  input  wave_t                 wr_wave,
  input  logic [VOICE_WDTH-1:0] rd_voice,
  output logic [6:0]            rd_note,
  output logic                  rd_gate,
  output wave_t                 rd_wave,
  output logic [PH_WDTH-1:0]    rd_phase,
  input  logic                  upd_en,
  input  logic [VOICE_WDTH-1:0] upd_voice,
  input  logic [PH_WDTH-1:0]    upd_step
);

  logic [6:0]         note_q  [VOICES];
  logic               gate_q  [VOICES];
  wave_t              wave_q  [VOICES];
  logic [PH_WDTH-1:0] phase_q [VOICES];
  logic               phase_clr;

`ifdef POLY_DDS_PHASE_RESET_EN
  assign phase_clr = we && wr_gate && !gate_q[wr_voice];
`else
  assign phase_clr = 1'b0;
`endif

  assign rd_note  = note_q[rd_voice];
  assign rd_gate  = gate_q[rd_voice];
  assign rd_wave  = wave_q[rd_voice];
  assign rd_phase = phase_q[rd_voice];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < VOICES; i++) begin
        note_q[i]  <= 7'd0;
        gate_q[i]  <= 1'b0;
        wave_q[i]  <= WAVE_SINE;
        phase_q[i] <= '0;
      end
    end else begin
      if (we) begin
        note_q[wr_voice] <= wr_note;
        gate_q[wr_voice] <= wr_gate;
        wave_q[wr_voice] <= wr_wave;
      end
      // A gate-rise clear takes priority over a same-cycle phase advance.
      for (int i = 0; i < VOICES; i++) begin
        if (phase_clr && (wr_voice == VOICE_WDTH'(i)))
          phase_q[i] <= '0;
        else if (upd_en && (upd_voice == VOICE_WDTH'(i)))
          phase_q[i] <= phase_q[i] + upd_step;
      end
    end
  end

endmodule

// File: rtl/sine_lookup.sv
// Sine ROM with one-cycle read latency. Each half period is a scaled parabola
// x*(N-x), negated in the second half.
module sine_lookup #(
  parameter int ADDR_WDTH = 12,
  parameter int DATA_WDTH = 24
) (
  input  logic                        clk,
  input  logic        [ADDR_WDTH-1:0] addr,
  output logic signed [DATA_WDTH-1:0] data
);

  localparam int HW = ADDR_WDTH - 1;
  localparam logic [63:0] HALF = 64'd1 << HW;
  localparam logic [63:0] PEAK = (64'd1 << (DATA_WDTH - 1)) - 64'd1;

  logic [63:0]                 x;
  logic [63:0]                 prod;
  logic [63:0]                 scaled;
  logic signed [DATA_WDTH-1:0] mag;
  logic signed [DATA_WDTH-1:0] val;

  always_comb begin
    x      = 64'(addr[HW-1:0]);
    prod   = x * (HALF - x);
    scaled = (prod << (DATA_WDTH - 1)) >> (2 * ADDR_WDTH - 4);
    if (scaled > PEAK) scaled = PEAK;
    mag = DATA_WDTH'(scaled);
    val = addr[HW] ? -mag : mag;
  end

  always_ff @(posedge clk) begin
    data <= val;
  end

endmodule

// File: rtl/poly_dds.sv
// Time-multiplexed polyphonic DDS: one sweep over all voices per query_sine, signed mix out.
// Optional POLY_DDS_PHASE_RESET_EN (in poly_dds_voice_bank) restarts phase on gate rise.
module poly_dds
  import poly_dds_pkg::*;
#(
  parameter  int DATA_WDTH  = 24,
  parameter  int ADDR_WDTH  = 12,
  parameter  int CNTR_WDTH  = 4,
  parameter  int VOICES     = 4,
  localparam int VOICE_WDTH = $clog2(VOICES),
  localparam int MIX_WDTH   = DATA_WDTH + VOICE_WDTH,
  localparam int PH_WDTH    = ADDR_WDTH + CNTR_WDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       note_we,
  input  logic [VOICE_WDTH-1:0]      note_voice,
  input  logic [6:0]                 note,
  input  logic                       gate,
  input  logic [1:0]                 wave,
  input  logic                       query_sine,
  output logic                       busy,
  output logic signed [MIX_WDTH-1:0] sample,
  output logic                       sample_valid,
  output logic                       overrun
);

  // Handshake: query_sine is a single-cycle request, accepted only while busy=0;
  // sample_valid is a one-cycle pulse and sample holds until the next accepted sweep.

  localparam logic signed [DATA_WDTH-1:0] SQ_POS = DATA_WDTH'(square_amp(DATA_WDTH));
  localparam logic signed [DATA_WDTH-1:0] SQ_NEG = -SQ_POS;

  state_t                state;
  logic [VOICE_WDTH-1:0] vidx;
  logic                  drain_cnt;
  logic signed [MIX_WDTH-1:0] acc;

  logic [6:0]         rd_note;
  logic               rd_gate;
  wave_t              rd_wave;
  logic [PH_WDTH-1:0] rd_phase;
  logic [PH_WDTH-1:0] rom_step;
  logic signed [DATA_WDTH-1:0] rom_sine;

  logic                  s1_vld, s2_vld;
  logic [VOICE_WDTH-1:0] s1_voice, s2_voice;
  logic                  s1_gate, s2_gate;
  wave_t                 s1_wave, s2_wave;
  logic [PH_WDTH-1:0]    s1_phase, s2_phase;
  logic [PH_WDTH-1:0]    step_q;
  logic signed [DATA_WDTH-1:0] sine_q;

  logic [PH_WDTH-1:0]          saw_ph;
  logic signed [DATA_WDTH-1:0] vval;

  assign overrun = query_sine && busy;

  poly_dds_voice_bank #(
    .VOICES    (VOICES),
    .VOICE_WDTH(VOICE_WDTH),
    .PH_WDTH   (PH_WDTH)
  ) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (note_we),
    .wr_voice (note_voice),
    .wr_note  (note),
    .wr_gate  (gate),
    .wr_wave  (wave_t'(wave)),
    .rd_voice (vidx),
    .rd_note  (rd_note),
    .rd_gate  (rd_gate),
    .rd_wave  (rd_wave),
    .rd_phase (rd_phase),
    .upd_en   (s2_vld && s2_gate),
    .upd_voice(s2_voice),
    .upd_step (step_q)
  );

  note_lookup #(.PH_WDTH(PH_WDTH)) u_note (
    .clk (clk),
    .addr(rd_note),
    .step(rom_step)
  );

  sine_lookup #(.ADDR_WDTH(ADDR_WDTH), .DATA_WDTH(DATA_WDTH)) u_sine (
    .clk (clk),
    .addr(rd_phase[PH_WDTH-1:CNTR_WDTH]),
    .data(rom_sine)
  );

  // Voice value from the pre-increment phase captured at issue.
  always_comb begin
    saw_ph = {~s2_phase[PH_WDTH-1], s2_phase[PH_WDTH-2:0]};
    vval   = '0;
    if (s2_gate) begin
      case (s2_wave)
        WAVE_SINE:   vval = sine_q;
        WAVE_SAW:    vval = DATA_WDTH'(saw_ph) << (DATA_WDTH - PH_WDTH);
        WAVE_SQUARE: vval = s2_phase[PH_WDTH-1] ? SQ_NEG : SQ_POS;
        default:     vval = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s2_vld   <= 1'b0;
      s1_voice <= '0;
      s2_voice <= '0;
      s1_gate  <= 1'b0;
      s2_gate  <= 1'b0;
      s1_wave  <= WAVE_SINE;
      s2_wave  <= WAVE_SINE;
      s1_phase <= '0;
      s2_phase <= '0;
      step_q   <= '0;
      sine_q   <= '0;
    end else begin
      s1_vld   <= (state == SWEEP);
      s1_voice <= vidx;
      s1_gate  <= rd_gate;
      s1_wave  <= rd_wave;
      s1_phase <= rd_phase;
      s2_vld   <= s1_vld;
      s2_voice <= s1_voice;
      s2_gate  <= s1_gate;
      s2_wave  <= s1_wave;
      s2_phase <= s1_phase;
      step_q   <= rom_step;
      sine_q   <= rom_sine;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      vidx         <= '0;
      drain_cnt    <= 1'b0;
      acc          <= '0;
      busy         <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      busy         <= (state != IDLE);
      sample_valid <= 1'b0;
      if (s2_vld) acc <= acc + MIX_WDTH'(vval);
      case (state)
        IDLE: begin
          if (query_sine && !busy) begin
            state <= SWEEP;
            vidx  <= '0;
            acc   <= '0;
          end
        end
        SWEEP: begin
          vidx <= vidx + VOICE_WDTH'(1);
          if (vidx == VOICE_WDTH'(VOICES - 1)) begin
            state     <= DRAIN;
            drain_cnt <= 1'b0;
          end
        end
        DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) state <= DONE;
        end
        DONE: begin
          sample       <= acc;
          sample_valid <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_dds.sv
// Self-checking bench for poly_dds: table of single-sweep vectors plus hand-written
// sequences for phase advance, overrun, mid-sweep reset and gate retrigger.
module tb_poly_dds;

  localparam int VOICES   = 4;
  localparam int MIX_WDTH = 26;
  localparam int LAT      = VOICES + 3;
  localparam longint SQ   = 8388607;

  logic                clk;
  logic                rst_n;
  logic                note_we;
  logic [1:0]          note_voice;
  logic [6:0]          note;
  logic                gate;
  logic [1:0]          wave;
  logic                query_sine;
  logic                busy;
  logic [MIX_WDTH-1:0] sample;
  logic                sample_valid;
  logic                overrun;

  poly_dds u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .note_we     (note_we),
    .note_voice  (note_voice),
    .note        (note),
    .gate        (gate),
    .wave        (wave),
    .query_sine  (query_sine),
    .busy        (busy),
    .sample      (sample),
    .sample_valid(sample_valid),
    .overrun     (overrun)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [MIX_WDTH-1:0] exp_q[$];

  typedef struct {
    logic [3:0]      gate;
    logic [3:0][1:0] wave;
    longint          exp;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // driver tasks: all start and end 1 time unit after a rising edge
  task automatic write_voice(input int v, input int n, input bit g, input int w);
    note_we    = 1'b1;
    note_voice = 2'(v);
    note       = 7'(n);
    gate       = g;
    wave       = 2'(w);
    @(posedge clk);
    #1 note_we = 1'b0;
  endtask

  task automatic run_sweep(input bit want, input int ovr_at, input int rst_at);
    bit seen;
    bit aborted;
    bit exp_busy;
    logic [MIX_WDTH-1:0] e;
    seen    = 0;
    aborted = 0;
    query_sine = 1'b1;
    @(posedge clk);
    #1 query_sine = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1 query_sine = 1'b0;
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        aborted = 1;
        check("rst_busy", longint'(busy), 0);
        check("rst_sample", longint'(sample), 0);
        check("rst_valid", longint'(sample_valid), 0);
        check("rst_ph0", longint'(u_dut.u_bank.phase_q[0]), 0);
        check("rst_ph1", longint'(u_dut.u_bank.phase_q[1]), 0);
        check("rst_ph2", longint'(u_dut.u_bank.phase_q[2]), 0);
        check("rst_ph3", longint'(u_dut.u_bank.phase_q[3]), 0);
        #1 rst_n = 1'b1;
      end else begin
        exp_busy = !aborted && (k <= LAT);
        if (k <= LAT + 2) check("busy", longint'(busy), longint'(exp_busy));
      end
      if (k == ovr_at) begin
        query_sine = 1'b1;
        #1 check("overrun", longint'(overrun), 1);
      end
      if (sample_valid) begin
        if (aborted || seen) begin
          check("spurious_valid", k, -1);
        end else begin
          seen = 1;
          check("valid_cycle", k, LAT);
          if (exp_q.size() == 0) begin
            check("sb_empty_pop", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("sample", longint'($signed(sample)), longint'($signed(e)));
          end
        end
      end
    end
    if (want && !seen) check("valid_timeout", 0, 1);
  endtask

  initial begin
    longint ph;
    longint step_exp;
    longint e;
    rst_n      = 1'b0;
    note_we    = 1'b0;
    note_voice = 2'd0;
    note       = 7'd0;
    gate       = 1'b0;
    wave       = 2'd0;
    query_sine = 1'b0;

    // {gates v3..v0, waves v3..v0, expected mix of first sweep from reset}
    vecs[0] = '{4'b0000, 8'b00_00_00_00, 0};
    vecs[1] = '{4'b0001, 8'b00_00_00_10, SQ};
    vecs[2] = '{4'b1111, 8'b10_10_10_10, 4 * SQ};
    vecs[3] = '{4'b0100, 8'b00_01_00_00, -8388608};
    vecs[4] = '{4'b1010, 8'b01_00_10_00, SQ - 8388608};
    vecs[5] = '{4'b0011, 8'b00_00_10_11, SQ};
    vecs[6] = '{4'b0000, 8'b00_00_01_10, 0};
    vecs[7] = '{4'b0001, 8'b00_00_00_00, 0};
    vecs[8] = '{4'b1111, 8'b01_01_10_10, 2 * SQ - 2 * 8388608};

    do_reset();
    check("reset_busy", longint'(busy), 0);
    check("reset_sample", longint'(sample), 0);
    check("reset_valid", longint'(sample_valid), 0);
    check("reset_overrun", longint'(overrun), 0);

    for (int i = 0; i < 9; i++) begin
      do_reset();
      for (int v = 0; v < VOICES; v++)
        write_voice(v, int'($urandom_range(0, 127)), vecs[i].gate[v], int'(vecs[i].wave[v]));
      exp_q.push_back(MIX_WDTH'(vecs[i].exp));
      run_sweep(1, -1, -1);
    end

    // saw on voice 2, note 69 (A4): step = floor(440*65536/48000)
    step_exp = longint'($rtoi(440.0 * 65536.0 / 48000.0));
    do_reset();
    write_voice(2, 69, 1, 1);
    exp_q.push_back(MIX_WDTH'(-8388608));
    run_sweep(1, -1, -1);
    check("saw_phase", longint'(u_dut.u_bank.phase_q[2]), step_exp);
    exp_q.push_back(MIX_WDTH'((step_exp - 32768) * 256));
    run_sweep(1, -1, -1);
    check("saw_phase2", longint'(u_dut.u_bank.phase_q[2]), 2 * step_exp);

    // query while busy: overrun at cycle 3, single sample, no second sweep
    do_reset();
    for (int v = 0; v < VOICES; v++) write_voice(v, 60, 1, 2);
    exp_q.push_back(MIX_WDTH'(4 * SQ));
    run_sweep(1, 3, -1);

    // reset during a sweep
    do_reset();
    write_voice(0, 69, 1, 2);
    exp_q.push_back(MIX_WDTH'(SQ));
    run_sweep(1, -1, -1);
    run_sweep(0, -1, 2);

    // long run then gate off/on on voice 0
    do_reset();
    write_voice(0, 69, 1, 2);
    ph = 0;
    for (int i = 0; i < 100; i++) begin
      e = ph[15] ? -SQ : SQ;
      exp_q.push_back(MIX_WDTH'(e));
      run_sweep(1, -1, -1);
      ph = (ph + step_exp) % 65536;
    end
    write_voice(0, 69, 0, 2);
    exp_q.push_back(MIX_WDTH'(0));
    run_sweep(1, -1, -1);
    check("held_phase", longint'(u_dut.u_bank.phase_q[0]), ph);
    write_voice(0, 69, 1, 2);
`ifdef POLY_DDS_PHASE_RESET_EN
    ph = 0;
`endif
    e = ph[15] ? -SQ : SQ;
    exp_q.push_back(MIX_WDTH'(e));
    run_sweep(1, -1, -1);

    check("sb_leftover", longint'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
